// File: rtl/node_iter_ctrl.sv
// Iteration controller: drives one child node CNT times to compute f^N(x),
// feeding each child result back as the next input. TIMEOUT must be >= 4.
module node_iter_ctrl #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         st_i,
    input  logic [W-1:0] in_i,
    input  logic [W-1:0] cnt_i,
    output logic         rd_o,
    output logic [W-1:0] res_o,
    output logic         err_o,
    output logic         cst_o,
    output logic [W-1:0] cin_o,
    input  logic         crd_i,
    input  logic [W-1:0] cres_i
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t         state_q;
    logic           st_old_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   rem_q;
    logic [WDW-1:0] wdog_q;
    logic           abort_q;
    logic           rd_q;
    logic [W-1:0]   res_q;
    logic           err_q;
    logic           cst_q;
    logic [W-1:0]   cin_q;

    logic           start_s;
    logic           wdog_expired_s;
    logic [WDW-1:0] wdog_inc_s;

    assign start_s        = st_i & ~st_old_q;
    // The increment that would make wdog reach TIMEOUT is the abort point.
    assign wdog_expired_s = (wdog_q == WDW'(TIMEOUT - 1));
    assign wdog_inc_s     = wdog_q + WDW'(1);

    // Start-edge detector history; tracks ST even while in reset.
    always_ff @(posedge clk_i) begin
        st_old_q <= st_i;
    end

    // Controller FSM with registered handshake and data outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= {W{1'b0}};
            rem_q   <= {W{1'b0}};
            wdog_q  <= {WDW{1'b0}};
            abort_q <= 1'b0;
            rd_q    <= 1'b1;
            res_q   <= {W{1'b0}};
            err_q   <= 1'b0;
            cst_q   <= 1'b0;
            cin_q   <= {W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        acc_q   <= in_i;
                        rem_q   <= cnt_i;
                        rd_q    <= 1'b0;
                        err_q   <= 1'b0;
                        abort_q <= 1'b0;
                        state_q <= (cnt_i == {W{1'b0}}) ? S_DONE : S_LAUNCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    cin_q   <= acc_q;
                    cst_q   <= 1'b1;
                    wdog_q  <= {WDW{1'b0}};
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!crd_i) begin
                        cst_q   <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end else if (wdog_expired_s) begin
                        cst_q   <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wdog_q  <= wdog_inc_s;
                    end
                end
                S_WAIT_DONE: begin
                    if (crd_i) begin
                        acc_q   <= cres_i;
                        rem_q   <= rem_q - W'(1);
                        // Exit on rem==1 so a full-scale count never wraps.
                        state_q <= (rem_q == W'(1)) ? S_DONE : S_LAUNCH;
                    end else if (wdog_expired_s) begin
                        cst_q   <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wdog_q  <= wdog_inc_s;
                    end
                end
                S_DONE: begin
                    res_q   <= acc_q;
                    rd_q    <= 1'b1;
                    err_q   <= abort_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    cst_q   <= 1'b0;
                    rd_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_o  = rd_q;
    assign res_o = res_q;
    assign err_o = err_q;
    assign cst_o = cst_q;
    assign cin_o = cin_q;

endmodule

// File: tb/tb_node_iter_ctrl.sv
// Directed bench for node_iter_ctrl with an increment child (x -> x+1)
// that can be forced into a stuck, never-busy state.
module tb_node_iter_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         st;
    logic [W-1:0] in_v;
    logic [W-1:0] cnt_v;
    logic         rd;
    logic [W-1:0] res;
    logic         err;
    logic         cst;
    logic [W-1:0] cin;
    logic         crd;
    logic [W-1:0] cres;

    int checks = 0;
    int fails  = 0;

    // Increment child with the standard handshake
    logic         stuck   = 1'b0;
    logic         c_st_old = 1'b0;
    logic         c_rd    = 1'b1;
    logic [1:0]   c_ph    = 2'd0;
    logic [W-1:0] c_val   = '0;
    logic [W-1:0] c_res   = '0;

    // CST rising-edge monitor
    logic         cst_prev = 1'b0;
    int           rise_cnt = 0;
    logic [W-1:0] cin_log [0:63];

    node_iter_ctrl #(.W(W), .TIMEOUT(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .st_i   (st),
        .in_i   (in_v),
        .cnt_i  (cnt_v),
        .rd_o   (rd),
        .res_o  (res),
        .err_o  (err),
        .cst_o  (cst),
        .cin_o  (cin),
        .crd_i  (crd),
        .cres_i (cres)
    );

    always #5 clk = ~clk;

    assign crd  = stuck ? 1'b1 : c_rd;
    assign cres = c_res;

    always @(posedge clk) begin
        c_st_old <= cst;
        if (cst && !c_st_old && c_rd) begin
            c_rd  <= 1'b0;
            c_ph  <= 2'd1;
            c_val <= cin + 16'd1;
        end else if (c_ph == 2'd1) begin
            c_ph <= 2'd2;
        end else if (c_ph == 2'd2) begin
            c_rd  <= 1'b1;
            c_res <= c_val;
            c_ph  <= 2'd0;
        end
    end

    always @(posedge clk) begin
        cst_prev <= cst;
        if (cst && !cst_prev) begin
            if (rise_cnt < 64) cin_log[rise_cnt] <= cin;
            rise_cnt <= rise_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise ST so the next edge (E0) samples the 0->1 transition
    task automatic start(input logic [W-1:0] x, input logic [W-1:0] n);
        in_v  = x;
        cnt_v = n;
        st    = 1'b1;
        tick();
        st    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st = 1'b0; in_v = '0; cnt_v = '0;
        ticks(2);
        checks++; if (rd !== 1'b1)   begin fails++; $display("FAIL reset_rd: got %b expected 1", rd); end
        checks++; if (res !== 16'h0) begin fails++; $display("FAIL reset_res: got %h expected 0000", res); end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (cst !== 1'b0)  begin fails++; $display("FAIL reset_cst: got %b expected 0", cst); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_increment();
        int base = rise_cnt;
        start(16'd5, 16'd3);
        checks++; if (rd !== 1'b0)  begin fails++; $display("FAIL inc_rd_e0: got %b expected 0", rd); end
        tick();
        checks++; if (cst !== 1'b1) begin fails++; $display("FAIL inc_cst_e1: got %b expected 1", cst); end
        ticks(14);
        checks++; if (rd !== 1'b0)  begin fails++; $display("FAIL inc_rd_e15: got %b expected 0", rd); end
        tick();
        checks++; if (rd !== 1'b1)   begin fails++; $display("FAIL inc_rd_e16: got %b expected 1", rd); end
        checks++; if (res !== 16'd8) begin fails++; $display("FAIL inc_res: got %0d expected 8", res); end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL inc_err: got %b expected 0", err); end
        checks++; if (rise_cnt - base !== 3) begin fails++; $display("FAIL inc_calls: got %0d expected 3", rise_cnt - base); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cin_log[base+i] !== W'(5 + i)) begin
                fails++; $display("FAIL inc_cin%0d: got %0d expected %0d", i, cin_log[base+i], 5 + i);
            end
        end
        tick();
    endtask

    task automatic test_cnt_zero();
        int base = rise_cnt;
        in_v = 16'h1234; cnt_v = 16'd0; st = 1'b1;
        tick();
        checks++; if (rd !== 1'b0) begin fails++; $display("FAIL zero_rd_e0: got %b expected 0", rd); end
        tick();
        checks++; if (rd !== 1'b1)      begin fails++; $display("FAIL zero_rd_e1: got %b expected 1", rd); end
        checks++; if (res !== 16'h1234) begin fails++; $display("FAIL zero_res: got %h expected 1234", res); end
        // ST still held high: must not retrigger
        ticks(4);
        checks++; if (rd !== 1'b1) begin fails++; $display("FAIL zero_held_rd: got %b expected 1", rd); end
        checks++; if (rise_cnt - base !== 0) begin fails++; $display("FAIL zero_calls: got %0d expected 0", rise_cnt - base); end
        st = 1'b0;
        tick();
    endtask

    task automatic test_ignore_start();
        int base = rise_cnt;
        start(16'd10, 16'd2);
        ticks(3);
        st = 1'b1; in_v = 16'd100; cnt_v = 16'd5;
        tick();
        st = 1'b0;
        ticks(6);
        checks++; if (rd !== 1'b0) begin fails++; $display("FAIL ign_rd_e10: got %b expected 0", rd); end
        tick();
        checks++; if (rd !== 1'b1)    begin fails++; $display("FAIL ign_rd_e11: got %b expected 1", rd); end
        checks++; if (res !== 16'd12) begin fails++; $display("FAIL ign_res: got %0d expected 12", res); end
        ticks(4);
        checks++; if (rd !== 1'b1) begin fails++; $display("FAIL ign_no_queue: got %b expected 1", rd); end
        checks++; if (rise_cnt - base !== 2) begin fails++; $display("FAIL ign_calls: got %0d expected 2", rise_cnt - base); end
    endtask

    task automatic test_watchdog();
        int base = rise_cnt;
        stuck = 1'b1;
        start(16'd9, 16'd1);
        tick();
        checks++; if (cst !== 1'b1) begin fails++; $display("FAIL wd_cst_e1: got %b expected 1", cst); end
        ticks(7);
        checks++; if (cst !== 1'b1) begin fails++; $display("FAIL wd_cst_e8: got %b expected 1", cst); end
        tick();
        checks++; if (cst !== 1'b0) begin fails++; $display("FAIL wd_cst_e9: got %b expected 0", cst); end
        checks++; if (rd !== 1'b0)  begin fails++; $display("FAIL wd_rd_e9: got %b expected 0", rd); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL wd_err_e9: got %b expected 0", err); end
        tick();
        checks++; if (err !== 1'b1)  begin fails++; $display("FAIL wd_err_e10: got %b expected 1", err); end
        checks++; if (rd !== 1'b1)   begin fails++; $display("FAIL wd_rd_e10: got %b expected 1", rd); end
        checks++; if (res !== 16'd9) begin fails++; $display("FAIL wd_res: got %0d expected 9", res); end
        ticks(3);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL wd_err_hold: got %b expected 1", err); end
        checks++; if (rise_cnt - base !== 1) begin fails++; $display("FAIL wd_calls: got %0d expected 1", rise_cnt - base); end
        stuck = 1'b0;
        ticks(4);
    endtask

    task automatic test_reset_mid();
        start(16'd3, 16'd4);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL mid_err_clear: got %b expected 0", err); end
        ticks(6);
        checks++; if (cst !== 1'b1) begin fails++; $display("FAIL mid_cst_e6: got %b expected 1", cst); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cst !== 1'b0)  begin fails++; $display("FAIL mid_cst_e7: got %b expected 0", cst); end
        checks++; if (rd !== 1'b1)   begin fails++; $display("FAIL mid_rd_e7: got %b expected 1", rd); end
        checks++; if (res !== 16'd0) begin fails++; $display("FAIL mid_res_e7: got %0d expected 0", res); end
        ticks(5);
        start(16'd0, 16'd4);
        ticks(20);
        checks++; if (rd !== 1'b0) begin fails++; $display("FAIL mid_rd_e20: got %b expected 0", rd); end
        tick();
        checks++; if (rd !== 1'b1)   begin fails++; $display("FAIL mid_rd_e21: got %b expected 1", rd); end
        checks++; if (res !== 16'd4) begin fails++; $display("FAIL mid_res: got %0d expected 4", res); end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL mid_err: got %b expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_cnt_zero();
        test_ignore_start();
        test_watchdog();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/node_iter_ctrl.md
# node_iter_ctrl

- Iteration controller that sequences a single child node to compute f^N(x): the child is applied CNT times, each result fed back as the next input.
- Sits between a parent node and one generated child node, all using the standard node handshake (ST rising edge starts, RD=0 while busy, RES valid once RD returns to 1).
- Presents the same ST/RD/RES/IN handshake upward, so it composes in the node tree like any other node.
- A watchdog aborts a child that never completes its handshake.

## Interface

Parameters:
- W, 16: data width of IN, RES, CIN, CRES, CNT.
- TIMEOUT, 255: maximum number of cycles spent in WAIT_BUSY plus WAIT_DONE for one child call before abort; must be at least 4.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ST  in  1  start; a 0→1 transition, sampled against a registered STold, requests a computation.
- IN  in  W  initial value x, latched at the accepted start edge.
- CNT  in  W  iteration count N, latched at the accepted start edge.
- RD  out  1  ready; 0 while busy.
- RES  out  W  result f^N(x), valid while RD=1.
- ERR  out  1  1 if the last computation was aborted by the watchdog.
- CST  out  1  child start.
- CIN  out  W  child input.
- CRD  in  1  child ready.
- CRES  in  W  child result.

## Operation

- **Reset** (RST=1 at posedge):
  - RD=1, RES=0, ERR=0, CST=0, CIN=0.
  - Internal acc, rem and wdog cleared; state=IDLE.
  - STold is updated every cycle, including during reset.
- **States:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE.
- **IDLE:**
  - On ST=1 && STold=0: acc←IN, rem←CNT, RD←0, ERR←0.
  - Next state is DONE if CNT=0, else LAUNCH.
- **LAUNCH:**
  - CIN←acc, CST←1, wdog←0.
  - Next state WAIT_BUSY.
- **WAIT_BUSY:**
  - If CRD=0: CST←0, go to WAIT_DONE.
  - Else wdog←wdog+1.
- **WAIT_DONE:** if CRD=1:
  - acc←CRES, rem←rem−1.
  - Next state DONE if rem=1, else LAUNCH.
  - Otherwise wdog←wdog+1.
- **Watchdog:** in WAIT_BUSY or WAIT_DONE, if wdog reaches TIMEOUT:
  - CST←0, ERR←1, go to DONE.
  - acc keeps the last completed value.
- **DONE:** RES←acc, RD←1, go to IDLE.
- **Arithmetic:**
  - rem is unsigned W-bit.
  - acc takes CRES unmodified; the controller performs no arithmetic on data.
- **Boundary conditions:**
  - ST edges outside IDLE are ignored, and are not queued.
  - ST held high never retriggers; it needs a fresh 0→1 transition.
  - CNT=0 returns IN unchanged.
  - CNT=2^W−1 runs the full count; no wrap occurs because of the rem=1 exit test.
  - RST mid-operation aborts immediately: CST=0 and RD=1 at the next edge; a child left busy simply finishes unobserved.
  - RES holds its previous value until DONE.

## Timing

- Numbering the edge that samples the ST transition as E0:
  - RD=0 after E0.
  - First CST=1 after E1.
- With a standard child (RD=0 from the edge after ST rises, back to 1 two edges later), each iteration takes 5 cycles, LAUNCH to LAUNCH:
  - CST high for 2 cycles.
  - CST low for at least 3 cycles between calls, so the child's STold always sees 0.
- RD returns to 1, with RES valid, after edge E(5N+1).
  - N=0 → after E1.
- RES and RD change on the same edge.
- ERR is set on the DONE edge of an aborted run and held until the next accepted start or reset.

## Test plan

- Reset: RST=1 for 2 cycles → RD=1, RES=0, ERR=0, CST=0.
- Increment child, IN=5, CNT=3, ST pulse:
  - RES=8, RD=1 after E16, ERR=0.
  - Exactly 3 CST rising edges, with CIN=5, 6, 7.
- CNT=0, IN=0x1234: RES=0x1234 and RD=1 after E1; CST never asserted.
- Second ST edge issued at E4 of a CNT=2 run: ignored; RES=IN+2 at E11, and only one computation occurs.
- Stuck child, CRD tied to 1, TIMEOUT=8, CNT=1, IN=9: CST drops, then ERR=1, RD=1 and RES=9 after E10 (E1 LAUNCH, 8 WAIT_BUSY cycles, DONE).
- RST asserted at E7 of a CNT=4 run: RD=1 and CST=0 after E7; a subsequent clean start with IN=0, CNT=4 yields RES=4.
